// File: rtl/bcd_to_bin_pkg.sv
// Shared types and sizing for the 4-digit BCD to 14-bit binary converter.
// Also holds the digit-range check used when BCD_TO_BIN_INPUT_CHECK_EN is defined.
package bcd_to_bin_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 16;
    localparam int BIN_W      = 14;
    localparam int ITER       = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CORRECT = 2'd2
    } state_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Per-digit correction applied after each right shift of the BCD digit register.
module bcd_digit_sub3 (
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    assign corrected = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Sequential BCD to binary converter (shift-and-subtract-3, 14 iterations).
// Optional input digit check: define BCD_TO_BIN_INPUT_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold
// SHIFT   | shift {digits,bin} right by one, count iteration
// CORRECT | subtract 3 from every digit >= 8; finish after iteration 14
module bcd_to_bin_conv
    import bcd_to_bin_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    output logic [BIN_W-1:0] bin_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state, state_nxt;
    logic [BCD_W-1:0] digits, digits_nxt, digits_fix;
    logic [BIN_W-1:0] bin, bin_nxt, bin_out_nxt;
    logic [3:0]       iter_cnt, iter_cnt_nxt;
    logic             done_nxt;
    logic             start_bad;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_fix
        bcd_digit_sub3 u_sub3 (
            .digit     (digits[4*g +: 4]),
            .corrected (digits_fix[4*g +: 4])
        );
    end

`ifdef BCD_TO_BIN_INPUT_CHECK_EN
    logic err_nxt;

    assign start_bad = !bcd_valid(bcd_in);
    assign err_nxt   = (state == IDLE) && start && start_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else          err <= err_nxt;
    end
`else
    assign start_bad = 1'b0;
    assign err       = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        digits_nxt   = digits;
        bin_nxt      = bin;
        iter_cnt_nxt = iter_cnt;
        bin_out_nxt  = bin_out;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        // rejected request: report immediately, no conversion
                        bin_out_nxt = '0;
                        done_nxt    = 1'b1;
                    end else begin
                        digits_nxt   = bcd_in;
                        bin_nxt      = '0;
                        iter_cnt_nxt = '0;
                        state_nxt    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                {digits_nxt, bin_nxt} = {digits, bin} >> 1;
                iter_cnt_nxt          = iter_cnt + 4'd1;
                state_nxt             = CORRECT;
            end
            CORRECT: begin
                digits_nxt = digits_fix;
                if (iter_cnt == 4'(ITER)) begin
                    bin_out_nxt = bin;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            digits   <= '0;
            bin      <= '0;
            iter_cnt <= '0;
            bin_out  <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            digits   <= digits_nxt;
            bin      <= bin_nxt;
            iter_cnt <= iter_cnt_nxt;
            bin_out  <= bin_out_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// Directed bench for bcd_to_bin_conv: latency, results, busy/start interaction,
// mid-conversion reset, invalid digits and a strided back-to-back sweep.
module tb_bcd_to_bin_conv;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    int last_bin;
    bit hold_known;

    always #5 clk = ~clk;

    bcd_to_bin_conv dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Pulse start with bcd; optionally pulse a second start sampled at edge second_at.
    task automatic convert(input string tag, input logic [15:0] bcd, input int exp_val,
                           input bit check_val, input int second_at, input logic [15:0] second_bcd);
        int k;
        int pulses;
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        k = 0;
        while (!done && k < 40) begin
            if (k + 1 == second_at) begin
                start  = 1'b1;
                bcd_in = second_bcd;
            end
            @(posedge clk); #1;
            k++;
            if (k == second_at) start = 1'b0;
            if (k == 14 && hold_known) check({tag, "_hold"}, bin_out, last_bin);
        end
        check({tag, "_lat"}, k, 28);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_err"}, err, 0);
        if (check_val) begin
            check({tag, "_val"}, bin_out, exp_val);
            last_bin   = exp_val;
            hold_known = 1'b1;
        end else begin
            hold_known = 1'b0;
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check({tag, "_no_extra_done"}, pulses, 0);
    endtask

    task automatic sweep();
        int cur;
        int k;
        cur    = 1;
        bcd_in = to_bcd(cur);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            k = 0;
            while (!done && k < 40) begin
                @(posedge clk); #1;
                k++;
            end
            check("sweep_lat", k, 28);
            check("sweep_val", bin_out, cur);
            if (n < 29) begin
                // restart in the done cycle: 29-cycle spacing between done pulses
                cur    = cur + 337;
                bcd_in = to_bcd(cur);
                start  = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int pulses;
        reset_n    = 1'b1;
        start      = 1'b0;
        bcd_in     = '0;
        last_bin   = 0;
        hold_known = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_bin_out", bin_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        convert("c1234", 16'h1234, 1234, 1'b1, -1, 16'h0);
        convert("c9999", 16'h9999, 14'h270F, 1'b1, -1, 16'h0);
        convert("c0000", 16'h0000, 0, 1'b1, -1, 16'h0);
        convert("c0042", 16'h0042, 42, 1'b1, 5, 16'h0777);

        // reset during edge 10 of a conversion
        bcd_in = 16'h5678;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_bin_out", bin_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        last_bin = 0;
        convert("c0001", 16'h0001, 1, 1'b1, -1, 16'h0);

`ifdef BCD_TO_BIN_INPUT_CHECK_EN
        bcd_in = 16'h00A0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_done", done, 1);
        check("bad_err", err, 1);
        check("bad_bin_out", bin_out, 0);
        check("bad_busy", busy, 0);
        @(posedge clk); #1;
        check("bad_done_clr", done, 0);
        check("bad_err_clr", err, 0);
`else
        convert("bad", 16'h00A0, 0, 1'b0, -1, 16'h0);
`endif

        sweep();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
